// File: rtl/avalon_mem_pkg.sv
// Shared widths, state encoding and address shift for the Avalon memory loader.
package avalon_mem_pkg;

  localparam int LINE_W         = 512;
  localparam int BE_W           = 64;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 16;
  localparam int BYTE_SHIFT     = 6;
  localparam int WCNT_W         = $clog2(WORDS_PER_LINE);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WRITE,
    RD_REQ,
    RD_WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/avalon_word_packer.sv
// Packs a 32-bit valid/ready word stream into one 512-bit line; word k lands in bits [32k+31:32k].
module avalon_word_packer
  import avalon_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              ready_o,
  output logic              full_o,
  output logic [LINE_W-1:0] line_o
);

  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [LINE_W-1:0] pack_q, pack_d;
  logic              take;

  assign ready_o = en_i;
  assign take    = valid_i & en_i;
  assign full_o  = take & (wcnt_q == WCNT_W'(WORDS_PER_LINE - 1));
  assign line_o  = pack_q;

  always_comb begin
    pack_d = pack_q;
    wcnt_d = wcnt_q;
    if (clr_i) begin
      wcnt_d = '0;
    end else if (take) begin
      pack_d[wcnt_q*WORD_W +: WORD_W] = data_i;
      wcnt_d = wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt_q <= '0;
      pack_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      pack_q <= pack_d;
    end
  end

endmodule

// File: rtl/avalon_mem_loader.sv
// Avalon-MM master loading 16-word runs as 512-bit lines into consecutive (wrapping) line addresses.
// Optional readback compare enabled by defining AVALON_LOADER_READBACK_EN.
module avalon_mem_loader
  import avalon_mem_pkg::*;
#(
  parameter logic [63:0] BaseAddr  = 64'h0,
  parameter int          NumLines  = 512,
  parameter int          RdLatency = 1,
  localparam int         LW        = $clog2(NumLines)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              Start_i,
  input  logic [LW-1:0]     StartLine_i,
  input  logic [LW:0]       Len_i,
  input  logic [WORD_W-1:0] S_Data_i,
  input  logic              S_Valid_i,
  output logic              S_Ready_o,
  output logic              Busy_o,
  output logic              Done_o,
  output logic              Err_o,
  output logic [63:0]       AvalonAddr_o,
  output logic              AvalonRead_o,
  output logic              AvalonWrite_o,
  output logic [BE_W-1:0]   AvalonByteEnable_o,
  output logic [LINE_W-1:0] AvalonWriteData_o,
  input  logic [LINE_W-1:0] AvalonReadData_i,
  output logic              AvalonLock_o,
  input  logic              AvalonWaitReq_i
);

  state_e            state_q, state_d;
  logic [LW-1:0]     start_line_q, start_line_d;
  logic [LW:0]       len_q, len_d;
  logic [LW:0]       line_cnt_q, line_cnt_d;
  logic [LW:0]       line_nxt;
  logic [LW-1:0]     line_idx;
  logic              pk_clr, pk_full, pk_ready;
  logic [LINE_W-1:0] pack_line;
  logic              wr, rd, advance;

`ifdef AVALON_LOADER_READBACK_EN
  logic [2:0] rd_cnt_q, rd_cnt_d;
  logic       err_q, err_d;
`endif

  avalon_word_packer u_packer (
    .clk     (clk),
    .rstn    (rstn),
    .clr_i   (pk_clr),
    .en_i    (state_q == FILL),
    .valid_i (S_Valid_i),
    .data_i  (S_Data_i),
    .ready_o (pk_ready),
    .full_o  (pk_full),
    .line_o  (pack_line)
  );

  // Line index wraps naturally in LW bits, giving modulo-NumLines addressing.
  assign line_idx = start_line_q + line_cnt_q[LW-1:0];
  assign line_nxt = line_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    start_line_d = start_line_q;
    len_d        = len_q;
    line_cnt_d   = line_cnt_q;
    pk_clr       = 1'b0;
    wr           = 1'b0;
    rd           = 1'b0;
    advance      = 1'b0;
`ifdef AVALON_LOADER_READBACK_EN
    rd_cnt_d     = rd_cnt_q;
    err_d        = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start_i) begin
          start_line_d = StartLine_i;
          len_d        = Len_i;
          line_cnt_d   = '0;
          pk_clr       = 1'b1;
`ifdef AVALON_LOADER_READBACK_EN
          err_d        = 1'b0;
`endif
          state_d      = (Len_i == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (pk_full) state_d = WRITE;
      end
      WRITE: begin
        wr = 1'b1;
        if (!AvalonWaitReq_i) begin
`ifdef AVALON_LOADER_READBACK_EN
          state_d = RD_REQ;
`else
          advance = 1'b1;
`endif
        end
      end
`ifdef AVALON_LOADER_READBACK_EN
      RD_REQ: begin
        rd       = 1'b1;
        rd_cnt_d = '0;
        if (!AvalonWaitReq_i) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == 3'(RdLatency - 1)) begin
          if (AvalonReadData_i != pack_line) err_d = 1'b1;
          advance = 1'b1;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (advance) begin
      line_cnt_d = line_nxt;
      state_d    = (line_nxt == len_q) ? DONE : FILL;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      start_line_q <= '0;
      len_q        <= '0;
      line_cnt_q   <= '0;
`ifdef AVALON_LOADER_READBACK_EN
      rd_cnt_q     <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      start_line_q <= start_line_d;
      len_q        <= len_d;
      line_cnt_q   <= line_cnt_d;
`ifdef AVALON_LOADER_READBACK_EN
      rd_cnt_q     <= rd_cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign S_Ready_o          = pk_ready;
  assign Busy_o             = (state_q != IDLE);
  assign Done_o             = (state_q == DONE);
  assign AvalonWrite_o      = wr;
  assign AvalonRead_o       = rd;
  assign AvalonAddr_o       = (wr | rd) ? (BaseAddr + 64'({line_idx, {BYTE_SHIFT{1'b0}}})) : 64'h0;
  assign AvalonByteEnable_o = '1;
  assign AvalonWriteData_o  = pack_line;
  assign AvalonLock_o       = 1'b0;

`ifdef AVALON_LOADER_READBACK_EN
  assign Err_o = err_q;
`else
  logic unused_rd;
  assign unused_rd = (^AvalonReadData_i) ^ (RdLatency > 4);
  assign Err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_mem_loader.sv
// Scoreboard bench for avalon_mem_loader: random streams, stalls, wrap, Len=0, reset mid-job, readback.
module tb_avalon_mem_loader;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          Start_i = 1'b0;
  logic [8:0]    StartLine_i = '0;
  logic [9:0]    Len_i = '0;
  logic [31:0]   S_Data_i = '0;
  logic          S_Valid_i = 1'b0;
  logic          S_Ready_o, Busy_o, Done_o, Err_o;
  logic [63:0]   AvalonAddr_o;
  logic          AvalonRead_o, AvalonWrite_o;
  logic [63:0]   AvalonByteEnable_o;
  logic [511:0]  AvalonWriteData_o;
  logic [511:0]  AvalonReadData_i = '0;
  logic          AvalonLock_o;
  logic          AvalonWaitReq_i = 1'b0;

  avalon_mem_loader dut (
    .clk(clk), .rstn(rstn), .Start_i(Start_i), .StartLine_i(StartLine_i), .Len_i(Len_i),
    .S_Data_i(S_Data_i), .S_Valid_i(S_Valid_i), .S_Ready_o(S_Ready_o), .Busy_o(Busy_o),
    .Done_o(Done_o), .Err_o(Err_o), .AvalonAddr_o(AvalonAddr_o), .AvalonRead_o(AvalonRead_o),
    .AvalonWrite_o(AvalonWrite_o), .AvalonByteEnable_o(AvalonByteEnable_o),
    .AvalonWriteData_o(AvalonWriteData_o), .AvalonReadData_i(AvalonReadData_i),
    .AvalonLock_o(AvalonLock_o), .AvalonWaitReq_i(AvalonWaitReq_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; logic [511:0] data; } exp_t;
  exp_t         expq[$];
  int           total = 0, bad = 0;
  int           wr_cnt = 0, rd_cnt = 0, done_cnt = 0, hold = 0, last_hold = 0;
  logic [63:0]  h_addr, last_wr_addr = '0;
  logic [511:0] h_data, rd_next = '0;
  logic         err_at_wr[$];
  logic         done_err = 1'b0, rd_pend = 1'b0, rand_wait = 1'b0;
  int           stall_n = 0, corrupt_idx = -1;
  logic [511:0] mem [int];

  task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic flag(string nm);
    total++;
    bad++;
    $display("FAIL %s: condition violated at %0t", nm, $time);
  endtask

  // Monitor / scoreboard: everything is sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic [511:0] flip;
    int idx;
    if (AvalonWrite_o && AvalonRead_o) flag("rd_wr_together");
    if (AvalonWrite_o) begin
      if (hold == 0) begin
        h_addr = AvalonAddr_o;
        h_data = AvalonWriteData_o;
      end else if (AvalonAddr_o !== h_addr || AvalonWriteData_o !== h_data) begin
        flag("write_hold_stable");
      end
      hold++;
      if (S_Ready_o) flag("ready_during_write");
      if (!AvalonWaitReq_i) begin
        wr_cnt++;
        last_hold = hold;
        hold = 0;
        last_wr_addr = AvalonAddr_o;
        err_at_wr.push_back(Err_o);
        mem[int'(AvalonAddr_o >> 6)] = AvalonWriteData_o;
        if (expq.size() == 0) flag("unexpected_write");
        else begin
          e = expq.pop_front();
          chk("wr_addr", 512'(AvalonAddr_o), 512'(e.addr));
          chk("wr_data", AvalonWriteData_o, e.data);
          chk("wr_be", 512'(AvalonByteEnable_o), 512'({64{1'b1}}));
        end
      end
    end else begin
      hold = 0;
    end
    if (AvalonRead_o && !AvalonWaitReq_i) begin
      rd_cnt++;
      chk("rd_addr", 512'(AvalonAddr_o), 512'(last_wr_addr));
      idx = int'(AvalonAddr_o >> 6);
      flip = '0;
      if (idx == corrupt_idx) flip[100] = 1'b1;
      rd_next = mem.exists(idx) ? (mem[idx] ^ flip) : flip;
      rd_pend = 1'b1;
    end
    if (Done_o) begin
      done_cnt++;
      done_err = Err_o;
    end
  end

  // Slave model: waitrequest generation and read-data return one cycle after accept.
  always @(posedge clk) begin
    #1;
    if (stall_n > 0 && AvalonWrite_o) begin
      AvalonWaitReq_i = 1'b1;
      stall_n--;
    end else begin
      AvalonWaitReq_i = rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
    if (rd_pend) begin
      AvalonReadData_i = rd_next;
      rd_pend = 1'b0;
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_job(int sl, int len);
    StartLine_i = 9'(sl);
    Len_i = 10'(len);
    Start_i = 1'b1;
    cyc(1);
    Start_i = 1'b0;
  endtask

  task automatic send_word(logic [31:0] w);
    int t = 0;
    if ($urandom_range(0, 3) == 0) cyc(1);
    S_Data_i = w;
    S_Valid_i = 1'b1;
    forever begin
      @(negedge clk);
      if (S_Ready_o) break;
      if (++t > 300) begin
        flag("ready_timeout");
        S_Valid_i = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    S_Valid_i = 1'b0;
  endtask

  task automatic run_job(int sl, int len, bit seq, bit poke);
    logic [511:0] line;
    logic [31:0]  w;
    start_job(sl, len);
    for (int j = 0; j < len; j++) begin
      line = '0;
      for (int k = 0; k < 16; k++) begin
        w = seq ? 32'(j * 16 + k) : $urandom;
        line[k*32 +: 32] = w;
        send_word(w);
        if (poke && j == 0 && k == 8) start_job(100, 1);
      end
      expq.push_back('{64'(((sl + j) % 512) * 64), line});
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    forever begin
      @(negedge clk);
      if (!Busy_o) break;
      if (++t > 3000) begin
        flag("busy_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_ready"}, 512'(S_Ready_o), 512'(0));
    chk({tag, "_busy"}, 512'(Busy_o), 512'(0));
    chk({tag, "_done"}, 512'(Done_o), 512'(0));
    chk({tag, "_err"}, 512'(Err_o), 512'(0));
    chk({tag, "_addr"}, 512'(AvalonAddr_o), 512'(0));
    chk({tag, "_rdwr"}, 512'({AvalonRead_o, AvalonWrite_o, AvalonLock_o}), 512'(0));
    chk({tag, "_be"}, 512'(AvalonByteEnable_o), 512'({64{1'b1}}));
    chk({tag, "_wdata"}, AvalonWriteData_o, 512'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, w0, sl, len;
    cyc(2);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc(2);

    // Single line, sequential words 0..15 at line 5
    d0 = done_cnt; w0 = wr_cnt;
    run_job(5, 1, 1'b1, 1'b0);
    wait_idle();
    chk("t1_done", 512'(done_cnt - d0), 512'(1));
    chk("t1_writes", 512'(wr_cnt - w0), 512'(1));
    chk("t1_busy_after", 512'(Busy_o), 512'(0));

    // Waitrequest stall of 5 cycles
    d0 = done_cnt; w0 = wr_cnt;
    stall_n = 5;
    run_job(37, 1, 1'b0, 1'b0);
    wait_idle();
    chk("t2_hold_cycles", 512'(last_hold), 512'(6));
    chk("t2_writes", 512'(wr_cnt - w0), 512'(1));

    // Wrap across the top of memory with random waitrequest
    w0 = wr_cnt;
    rand_wait = 1'b1;
    run_job(510, 4, 1'b0, 1'b0);
    wait_idle();
    rand_wait = 1'b0;
    chk("t3_writes", 512'(wr_cnt - w0), 512'(4));

    // Len=0, with Start still held while in DONE
    d0 = done_cnt; w0 = wr_cnt;
    StartLine_i = 9'd9; Len_i = 10'd0; Start_i = 1'b1;
    cyc(1);
    StartLine_i = 9'd3; Len_i = 10'd1;
    @(negedge clk);
    chk("t4_done_pulse", 512'(Done_o), 512'(1));
    @(posedge clk);
    #1;
    Start_i = 1'b0;
    @(negedge clk);
    chk("t4_done_low", 512'(Done_o), 512'(0));
    chk("t4_start_in_done_ignored", 512'(Busy_o), 512'(0));
    cyc(2);
    chk("t4_done_cnt", 512'(done_cnt - d0), 512'(1));
    chk("t4_no_traffic", 512'(wr_cnt - w0), 512'(0));

    // Start during a busy Len=2 job is ignored
    d0 = done_cnt; w0 = wr_cnt;
    run_job(200, 2, 1'b0, 1'b1);
    wait_idle();
    chk("t5_writes", 512'(wr_cnt - w0), 512'(2));
    chk("t5_done", 512'(done_cnt - d0), 512'(1));

    // Reset after 7 accepted words
    d0 = done_cnt; w0 = wr_cnt;
    start_job(50, 1);
    for (int k = 0; k < 7; k++) send_word($urandom);
    #2;
    rstn = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc(3);
    chk("t6_no_write", 512'(wr_cnt - w0), 512'(0));
    chk("t6_no_done", 512'(done_cnt - d0), 512'(0));
    run_job(60, 1, 1'b0, 1'b0);
    wait_idle();
    chk("t6_reload_writes", 512'(wr_cnt - w0), 512'(1));

    // Random jobs
    for (int i = 0; i < 3; i++) begin
      w0 = wr_cnt;
      sl = $urandom_range(0, 511);
      len = $urandom_range(1, 3);
      rand_wait = $urandom_range(0, 1) == 1;
      run_job(sl, len, 1'b0, 1'b0);
      wait_idle();
      chk("rand_writes", 512'(wr_cnt - w0), 512'(len));
    end
    rand_wait = 1'b0;

`ifdef AVALON_LOADER_READBACK_EN
    // Readback: second of three lines comes back with bit 100 flipped
    err_at_wr.delete();
    w0 = rd_cnt;
    corrupt_idx = 301;
    run_job(300, 3, 1'b0, 1'b0);
    wait_idle();
    chk("rb_reads", 512'(rd_cnt - w0), 512'(3));
    chk("rb_wr_seen", 512'(err_at_wr.size()), 512'(3));
    if (err_at_wr.size() == 3) begin
      chk("rb_err_before_2nd_cmp", 512'(err_at_wr[1]), 512'(0));
      chk("rb_err_after_2nd_cmp", 512'(err_at_wr[2]), 512'(1));
    end
    chk("rb_err_at_done", 512'(done_err), 512'(1));
    chk("rb_err_sticky", 512'(Err_o), 512'(1));
    corrupt_idx = -1;
    start_job(0, 0);
    @(negedge clk);
    chk("rb_err_cleared", 512'(Err_o), 512'(0));
    wait_idle();
`endif

    chk("queue_empty", 512'(expq.size()), 512'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
